flicker_ctrl: RTL and testbench

FLICKER_CTRL -- requirements
Module: flicker_ctrl

---
 rtl/flicker_pkg.sv | 14 +
 rtl/edge_sync.sv | 34 +++
 rtl/flicker_ctrl.sv | 97 +++++++++
 tb/tb_flicker_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flicker_pkg.sv
// Shared types and default sizing for the display flicker controller.
// Holds the FSM state encoding used by flicker_ctrl.
package flicker_pkg;

    localparam int DEFAULT_CNT_W       = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OFF  = 2'd1,
        ON   = 2'd2
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level into the clk domain and emits a
// single-cycle pulse on each synchronized rising edge.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise_pulse
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   arm_q;

    // arm_q fills with ones after reset release so that a level already high
    // at release is absorbed into prev_q instead of being seen as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_async};
            prev_q <= sync_q[STAGES-1];
            arm_q  <= {arm_q[STAGES-1:0], 1'b1};
        end
    end

    assign rise_pulse = sync_q[STAGES-1] & ~prev_q & arm_q[STAGES];

endmodule

// File: rtl/flicker_ctrl.sv
// Display flicker controller: blanks and re-shows the display for a
// requested number of OFF/ON pairs, paced by rising edges of slow_clk.
module flicker_ctrl
    import flicker_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_flashes,
    output logic             visible,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             done_d;
    logic             tick;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk       (clk),
        .rst       (rst),
        .d_async   (slow_clk),
        .rise_pulse(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            visible     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            visible     <= (state_d != OFF);
            busy        <= (state_d != IDLE);
            done        <= done_d;
        end
    end

    // Priority is abort, then start, then tick; a tick arriving with start in
    // IDLE is simply dropped, so the first OFF phase lasts a full period.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    if (num_flashes != '0) begin
                        remaining_d = num_flashes;
                        state_d     = OFF;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            OFF: begin
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (tick) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (tick) begin
                    if (remaining_q == CNT_W'(1)) begin
                        state_d     = IDLE;
                        remaining_d = '0;
                        done_d      = 1'b1;
                    end else begin
                        state_d     = OFF;
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_flicker_ctrl.sv
// Directed bench for flicker_ctrl: slow_clk is driven by hand with a
// 16-cycle period and outputs are compared on every falling clk edge.
module tb_flicker_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       slow_clk;
    logic       start;
    logic       abort;
    logic [3:0] num_flashes;
    logic       visible;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    flicker_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .slow_clk   (slow_clk),
        .start      (start),
        .abort      (abort),
        .num_flashes(num_flashes),
        .visible    (visible),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // slow_clk square wave: first rise at cycle 'first', high 8, low 8
    function automatic logic slow_at(input int c, input int first);
        return (c >= first) && (((c - first) % 16) < 8);
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({visible, busy, done} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: got vis/busy/done=%b expected 100", {visible, busy, done});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({visible, busy, done} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got vis/busy/done=%b expected 100", {visible, busy, done});
        end
    endtask

    task automatic test_zero_flashes();
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        num_flashes = 4'd0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({visible, busy, done} !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL zero_done: got vis/busy/done=%b expected 101", {visible, busy, done});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({visible, busy, done} !== 3'b100) begin
                n_fail++;
                $display("[TB] FAIL zero_after i=%0d: got vis/busy/done=%b expected 100", i, {visible, busy, done});
            end
        end
    endtask

    // Full sequence of n pairs; optional ignored restart (num 7) at cycle restart_at
    task automatic test_sequence(input int n, input int restart_at, input string name);
        int   k;
        int   last_rise;
        logic exp_vis, exp_busy, exp_done;
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        num_flashes = 4'(n);
        @(negedge clk);
        start = 1'b0;
        num_flashes = 4'd9;
        last_rise = 4 + 16 * (2 * n - 1);
        for (int c = 0; c <= last_rise + 12; c++) begin
            k = (c >= 7) ? ((c - 7) / 16 + 1) : 0;
            if (k > 2 * n) k = 2 * n;
            exp_vis  = (k == 2 * n) ? 1'b1 : k[0];
            exp_busy = (k < 2 * n);
            exp_done = (c == last_rise + 3);
            n_checks++;
            if ({visible, busy, done} !== {exp_vis, exp_busy, exp_done}) begin
                n_fail++;
                $display("[TB] FAIL %s c=%0d: got vis/busy/done=%b expected %b",
                         name, c, {visible, busy, done}, {exp_vis, exp_busy, exp_done});
            end
            slow_clk = slow_at(c, 4);
            start = (c == restart_at);
            if (c == restart_at) num_flashes = 4'd7;
            @(negedge clk);
        end
        start = 1'b0;
        slow_clk = 1'b0;
    endtask

    task automatic test_abort();
        int   k;
        logic exp_vis, exp_busy;
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        num_flashes = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 70; c++) begin
            k = (c >= 7) ? ((c - 7) / 16 + 1) : 0;
            exp_vis  = (c > 30) ? 1'b1 : k[0];
            exp_busy = (c <= 30);
            n_checks++;
            if ({visible, busy, done} !== {exp_vis, exp_busy, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL abort c=%0d: got vis/busy/done=%b expected %b",
                         c, {visible, busy, done}, {exp_vis, exp_busy, 1'b0});
            end
            slow_clk = slow_at(c, 4);
            abort = (c == 30);
            @(negedge clk);
        end
        abort = 1'b0;
        slow_clk = 1'b0;
        test_sequence(1, -1, "after_abort");
    endtask

    task automatic test_start_with_tick();
        logic [2:0] exp;
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        num_flashes = 4'd3;
        for (int c = 0; c <= 25; c++) begin
            if (c <= 6)       exp = 3'b100;
            else if (c <= 22) exp = 3'b010;
            else if (c <= 24) exp = 3'b110;
            else              exp = 3'b100;
            n_checks++;
            if ({visible, busy, done} !== exp) begin
                n_fail++;
                $display("[TB] FAIL start_tick c=%0d: got vis/busy/done=%b expected %b", c, {visible, busy, done}, exp);
            end
            slow_clk = slow_at(c, 4);
            start = (c == 6);
            abort = (c == 24);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        slow_clk = 1'b0;
    endtask

    task automatic test_abort_idle_and_tick();
        logic [2:0] exp;
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        num_flashes = 4'd3;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({visible, busy, done} !== 3'b100) begin
                n_fail++;
                $display("[TB] FAIL start_abort_idle i=%0d: got vis/busy/done=%b expected 100", i, {visible, busy, done});
            end
            @(negedge clk);
        end
        for (int c = 0; c <= 30; c++) begin
            exp = (c >= 2 && c <= 6) ? 3'b010 : 3'b100;
            n_checks++;
            if ({visible, busy, done} !== exp) begin
                n_fail++;
                $display("[TB] FAIL abort_tick c=%0d: got vis/busy/done=%b expected %b", c, {visible, busy, done}, exp);
            end
            slow_clk = slow_at(c, 4);
            start = (c == 1);
            abort = (c == 6);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        slow_clk = 1'b0;
    endtask

    task automatic test_reset_mid_on();
        logic [2:0] exp;
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        num_flashes = 4'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            slow_clk = slow_at(c, 4);
            @(negedge clk);
        end
        n_checks++;
        if ({visible, busy, done} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_on: got vis/busy/done=%b expected 110", {visible, busy, done});
        end
        slow_clk = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({visible, busy, done} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got vis/busy/done=%b expected 100", {visible, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        num_flashes = 4'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({visible, busy, done} !== 3'b010) begin
                n_fail++;
                $display("[TB] FAIL no_spurious_tick i=%0d: got vis/busy/done=%b expected 010", i, {visible, busy, done});
            end
            @(negedge clk);
        end
        for (int c = 0; c <= 20; c++) begin
            exp = (c >= 15) ? 3'b110 : 3'b010;
            n_checks++;
            if ({visible, busy, done} !== exp) begin
                n_fail++;
                $display("[TB] FAIL post_reset_rise c=%0d: got vis/busy/done=%b expected %b", c, {visible, busy, done}, exp);
            end
            slow_clk = (c >= 12);
            @(negedge clk);
        end
        abort = 1'b1;
        slow_clk = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({visible, busy, done} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL cleanup_abort: got vis/busy/done=%b expected 100", {visible, busy, done});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        slow_clk = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_flashes = 4'd0;
        test_reset();
        test_zero_flashes();
        test_sequence(3, -1, "three_flashes");
        test_sequence(2, 20, "back_to_back");
        test_sequence(15, -1, "max_count");
        test_abort();
        test_start_with_tick();
        test_abort_idle_and_tick();
        test_reset_mid_on();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
